// File: rtl/alu_ctrl_exec_if.sv
// alu_ctrl_exec_if: request/response bundle between EX-stage control and the ALU.
// master = requester (control/pipeline side), slave = alu_ctrl_exec.
interface alu_ctrl_exec_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       alu_op;
   logic [5:0]       funct;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             out_valid;
   logic [WIDTH-1:0] result;
   logic             wb_en;
   logic [3:0]       ctrl;
   logic             ovf;
   logic             err;
   logic             busy;

   modport master (
      output in_valid, alu_op, funct, src_a, src_b,
      input  in_ready, out_valid, result, wb_en, ctrl, ovf, err, busy
   );

   modport slave (
      input  in_valid, alu_op, funct, src_a, src_b,
      output in_ready, out_valid, result, wb_en, ctrl, ovf, err, busy
   );
endinterface

// File: rtl/alu_ctrl_exec.sv
// alu_ctrl_exec: EX-stage ALU control decode, execute and registered result.
// Build option ALU_MULDIV_EN adds the multi-cycle mult/div engine, HI/LO and
// mfhi/mflo; without it those functs decode as illegal and the unit is always ready.
module alu_ctrl_exec #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic            clk,
   input logic            rst_n,
   alu_ctrl_exec_if.slave bus
);
   localparam logic [3:0] C_AND  = 4'b0000, C_OR   = 4'b0001, C_ADD  = 4'b0010,
                          C_XOR  = 4'b0011, C_SUB  = 4'b0110, C_SLT  = 4'b0111,
                          C_SLTU = 4'b1000, C_MFHI = 4'b1001, C_MFLO = 4'b1010,
                          C_NOR  = 4'b1100, C_MUL  = 4'b1101, C_DIV  = 4'b1110,
                          C_ILL  = 4'b1111;

   logic [3:0]       w_ctrl;
   logic             w_err, w_chk_add, w_chk_sub, w_ovf, w_acc, w_single;
   logic [WIDTH-1:0] w_sum, w_dif, w_res;
   logic             r_vld, r_wb, r_ovf, r_err;
   logic [WIDTH-1:0] r_result;
   logic [3:0]       r_ctrl;
`ifdef ALU_MULDIV_EN
   localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_SIGN = 2'd3;
   logic               w_mul, w_div, w_sgn;
   logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quo, w_rem, w_hi_new, w_lo_new;
   logic [WIDTH:0]     w_madd, w_trial;
   logic [2*WIDTH-1:0] w_prod;
   logic [1:0]         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_p;
   logic [WIDTH-1:0]   r_ma, r_hi, r_lo;
   logic               r_neg, r_rneg, r_dz, r_isdiv;
`endif

   // decode alu_op / funct into control code and op class
   always_comb begin
      w_ctrl = C_ILL; w_err = 1'b0; w_chk_add = 1'b0; w_chk_sub = 1'b0;
`ifdef ALU_MULDIV_EN
      w_mul = 1'b0; w_div = 1'b0; w_sgn = 1'b0;
`endif
      case (bus.alu_op)
         3'b000, 3'b011: w_ctrl = C_ADD;
         3'b001:         w_ctrl = C_SUB;
         3'b100:         w_ctrl = C_AND;
         3'b101:         w_ctrl = C_OR;
         3'b110:         w_ctrl = C_SLT;
         3'b010: begin
            case (bus.funct)
               6'h20: begin w_ctrl = C_ADD; w_chk_add = 1'b1; end
               6'h21: w_ctrl = C_ADD;
               6'h22: begin w_ctrl = C_SUB; w_chk_sub = 1'b1; end
               6'h23: w_ctrl = C_SUB;
               6'h24: w_ctrl = C_AND;
               6'h25: w_ctrl = C_OR;
               6'h26: w_ctrl = C_XOR;
               6'h27: w_ctrl = C_NOR;
               6'h2A: w_ctrl = C_SLT;
               6'h2B: w_ctrl = C_SLTU;
`ifdef ALU_MULDIV_EN
               6'h10: w_ctrl = C_MFHI;
               6'h12: w_ctrl = C_MFLO;
               6'h18: begin w_ctrl = C_MUL; w_mul = 1'b1; w_sgn = 1'b1; end
               6'h19: begin w_ctrl = C_MUL; w_mul = 1'b1; end
               6'h1A: begin w_ctrl = C_DIV; w_div = 1'b1; w_sgn = 1'b1; end
               6'h1B: begin w_ctrl = C_DIV; w_div = 1'b1; end
`endif
               default: w_err = 1'b1;
            endcase
         end
         default: w_err = 1'b1;
      endcase
   end

   assign w_sum = bus.src_a + bus.src_b;
   assign w_dif = bus.src_a - bus.src_b;
   // signed overflow: operands agree in sign (add) / differ (sub) and result sign flips
   assign w_ovf = (w_chk_add & (bus.src_a[WIDTH-1] == bus.src_b[WIDTH-1]) &
                   (w_sum[WIDTH-1] != bus.src_a[WIDTH-1])) |
                  (w_chk_sub & (bus.src_a[WIDTH-1] != bus.src_b[WIDTH-1]) &
                   (w_dif[WIDTH-1] != bus.src_a[WIDTH-1]));

   // single-cycle execute; illegal and multi-cycle codes produce 0
   always_comb begin
      w_res = '0;
      case (w_ctrl)
         C_ADD:  w_res = w_sum;
         C_SUB:  w_res = w_dif;
         C_AND:  w_res = bus.src_a & bus.src_b;
         C_OR:   w_res = bus.src_a | bus.src_b;
         C_XOR:  w_res = bus.src_a ^ bus.src_b;
         C_NOR:  w_res = ~(bus.src_a | bus.src_b);
         C_SLT:  w_res = {{(WIDTH-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
         C_SLTU: w_res = {{(WIDTH-1){1'b0}}, bus.src_a < bus.src_b};
`ifdef ALU_MULDIV_EN
         C_MFHI: w_res = r_hi;
         C_MFLO: w_res = r_lo;
`endif
         default: w_res = '0;
      endcase
   end

`ifdef ALU_MULDIV_EN
   assign bus.in_ready = (r_state == S_IDLE);
   assign bus.busy     = (r_state != S_IDLE);
   assign w_acc        = bus.in_valid & bus.in_ready;
   assign w_single     = w_acc & ~(w_mul | w_div);

   // signed variants run on magnitudes; signs are restored in SIGN
   assign w_abs_a = (w_sgn & bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
   assign w_abs_b = (w_sgn & bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
   // shift-add step: r_p = {partial product, remaining multiplier bits}
   assign w_madd  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_ma} : '0);
   // restoring step: r_p = {remainder, remaining dividend / quotient bits}
   assign w_trial = r_p[2*WIDTH-1:WIDTH-1] - {1'b0, r_ma};

   // sign fix-up of the finished engine result
   always_comb begin
      w_prod = r_neg  ? -r_p : r_p;
      w_quo  = r_neg  ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
      w_rem  = r_rneg ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
      if (r_isdiv) begin
         w_hi_new = w_rem;
         w_lo_new = r_dz ? '1 : w_quo;
      end else begin
         {w_hi_new, w_lo_new} = w_prod;
      end
   end

   // mult/div FSM and HI/LO registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE; r_cnt <= '0; r_p <= '0; r_ma <= '0;
         r_neg <= 1'b0; r_rneg <= 1'b0; r_dz <= 1'b0; r_isdiv <= 1'b0;
         r_hi <= '0; r_lo <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_acc && (w_mul || w_div)) begin
               r_state <= w_mul ? S_MUL : S_DIV;
               r_cnt   <= '0;
               r_isdiv <= w_div;
               r_ma    <= w_div ? w_abs_b : w_abs_a;
               r_p     <= {{WIDTH{1'b0}}, (w_div ? w_abs_a : w_abs_b)};
               r_neg   <= w_sgn & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
               r_rneg  <= w_sgn & bus.src_a[WIDTH-1];
               r_dz    <= (bus.src_b == '0);
            end
            S_MUL, S_DIV: begin
               if (r_state == S_MUL)
                  r_p <= {w_madd, r_p[WIDTH-1:1]};
               else if (!w_trial[WIDTH])
                  r_p <= {w_trial[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
               else
                  r_p <= {r_p[2*WIDTH-2:0], 1'b0};
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(WIDTH-1)) r_state <= S_SIGN;
            end
            default: begin
               r_hi    <= w_hi_new;
               r_lo    <= w_lo_new;
               r_state <= S_IDLE;
            end
         endcase
      end
   end
`else
   assign bus.in_ready = 1'b1;
   assign bus.busy     = 1'b0;
   assign w_acc        = bus.in_valid;
   assign w_single     = w_acc;
`endif

   // registered outputs; flags are 0 except in the completion cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= 1'b0; r_wb <= 1'b0; r_ovf <= 1'b0; r_err <= 1'b0;
         r_result <= '0; r_ctrl <= '0;
      end else begin
         r_vld <= 1'b0; r_wb <= 1'b0; r_ovf <= 1'b0; r_err <= 1'b0;
         if (w_single) begin
            r_vld    <= 1'b1;
            r_result <= w_res;
            r_ctrl   <= w_ctrl;
            r_err    <= w_err;
            r_ovf    <= w_ovf;
            r_wb     <= ~w_err & ~w_ovf;
         end
`ifdef ALU_MULDIV_EN
         else if (r_state == S_SIGN) begin
            r_vld    <= 1'b1;
            r_result <= w_lo_new;
            r_ctrl   <= r_isdiv ? C_DIV : C_MUL;
         end
`endif
      end
   end

   assign bus.out_valid = r_vld;
   assign bus.result    = r_result;
   assign bus.ctrl      = r_ctrl;
   assign bus.wb_en     = r_wb;
   assign bus.ovf       = r_ovf;
   assign bus.err       = r_err;
endmodule

// File: tb/tb_alu_ctrl_exec.sv
// tb_alu_ctrl_exec: directed table-driven bench for alu_ctrl_exec (WIDTH=32).
// Mult/div sequences are used when ALU_MULDIV_EN is defined, illegal-decode
// checks of those functs otherwise.
`timescale 1ns/1ps
module tb_alu_ctrl_exec;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   alu_ctrl_exec_if #(.WIDTH(W)) bus ();
   alu_ctrl_exec #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic [2:0]   op;
      logic [5:0]   fn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic [3:0]   ctrl;
      logic         wb;
      logic         ovf;
      logic         err;
   } vec_t;
   vec_t tv[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // called at a negedge; returns at the negedge after the accepting edge
   task automatic drive(input logic [2:0] op, input logic [5:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      bus.in_valid = 1'b1; bus.alu_op = op; bus.funct = fn; bus.src_a = a; bus.src_b = b;
      while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready stayed %b, required 1", bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

`ifdef ALU_MULDIV_EN
   task automatic wait_done(input string nm, input int exp_lat, input logic [3:0] exp_ctrl);
      int n = 1;
      chk({nm, "_busy"}, {62'd0, bus.busy, bus.in_ready}, 64'b10);
      while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
      chk({nm, "_lat"}, 64'(n), 64'(exp_lat));
      chk({nm, "_pulse"}, {55'd0, bus.out_valid, bus.wb_en, bus.err, bus.ovf, bus.busy, bus.ctrl},
          {55'd0, 5'b10000, exp_ctrl});
   endtask

   task automatic hilo(input string nm, input logic [W-1:0] hi, input logic [W-1:0] lo);
      drive(3'b010, 6'h10, '0, '0);
      chk({nm, "_hi"}, {30'd0, bus.out_valid, bus.wb_en, bus.result}, {30'd0, 2'b11, hi});
      drive(3'b010, 6'h12, '0, '0);
      chk({nm, "_lo"}, {30'd0, bus.out_valid, bus.wb_en, bus.result}, {30'd0, 2'b11, lo});
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t  v;
      int    n;
      int    pulses;
      bus.in_valid = 1'b0; bus.alu_op = '0; bus.funct = '0; bus.src_a = '0; bus.src_b = '0;
      #1;
      chk("reset_outs", {22'd0, bus.out_valid, bus.wb_en, bus.ovf, bus.err, bus.busy, bus.in_ready,
                         bus.ctrl, bus.result}, {22'd0, 6'b000001, 4'b0000, 32'h0});
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      tv.push_back('{3'b010, 6'h20, 32'h5,        32'h7,        32'hC,        4'b0010, 1'b1, 1'b0, 1'b0});
      tv.push_back('{3'b010, 6'h20, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b0010, 1'b0, 1'b1, 1'b0});
      tv.push_back('{3'b010, 6'h21, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b0010, 1'b1, 1'b0, 1'b0});
      tv.push_back('{3'b010, 6'h23, 32'h80000000, 32'h1,        32'h7FFFFFFF, 4'b0110, 1'b1, 1'b0, 1'b0});
      tv.push_back('{3'b010, 6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000, 1'b1, 1'b0, 1'b0});
      tv.push_back('{3'b010, 6'h25, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 4'b0001, 1'b1, 1'b0, 1'b0});
      tv.push_back('{3'b010, 6'h26, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 4'b0011, 1'b1, 1'b0, 1'b0});
      tv.push_back('{3'b010, 6'h27, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 4'b1100, 1'b1, 1'b0, 1'b0});
      tv.push_back('{3'b010, 6'h2A, 32'hFFFFFFFF, 32'h1,        32'h1,        4'b0111, 1'b1, 1'b0, 1'b0});
      tv.push_back('{3'b010, 6'h2B, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b1000, 1'b1, 1'b0, 1'b0});
      tv.push_back('{3'b010, 6'h3F, 32'h5,        32'h7,        32'h0,        4'b1111, 1'b0, 1'b0, 1'b1});
      tv.push_back('{3'b000, 6'h00, 32'h3,        32'h4,        32'h7,        4'b0010, 1'b1, 1'b0, 1'b0});
      tv.push_back('{3'b001, 6'h00, 32'h3,        32'h4,        32'hFFFFFFFF, 4'b0110, 1'b1, 1'b0, 1'b0});
      tv.push_back('{3'b100, 6'h00, 32'hC,        32'hA,        32'h8,        4'b0000, 1'b1, 1'b0, 1'b0});
      tv.push_back('{3'b101, 6'h00, 32'hC,        32'hA,        32'hE,        4'b0001, 1'b1, 1'b0, 1'b0});
      tv.push_back('{3'b110, 6'h00, 32'h80000000, 32'h0,        32'h1,        4'b0111, 1'b1, 1'b0, 1'b0});
      tv.push_back('{3'b111, 6'h00, 32'h1,        32'h1,        32'h0,        4'b1111, 1'b0, 1'b0, 1'b1});
      tv.push_back('{3'b011, 6'h00, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b0010, 1'b1, 1'b0, 1'b0});
      tv.push_back('{3'b010, 6'h22, 32'h80000000, 32'h1,        32'h7FFFFFFF, 4'b0110, 1'b0, 1'b1, 1'b0});

      foreach (tv[i]) begin
         v = tv[i];
         drive(v.op, v.fn, v.a, v.b);
         chk($sformatf("vec%0d", i),
             {24'd0, bus.out_valid, bus.result, bus.ctrl, bus.wb_en, bus.ovf, bus.err},
             {24'd0, 1'b1, v.res, v.ctrl, v.wb, v.ovf, v.err});
      end

      // no request: flags drop, result/ctrl hold the last value
      v = tv[tv.size()-1];
      @(negedge clk);
      chk("idle_hold", {25'd0, bus.out_valid, bus.wb_en, bus.ovf, bus.err, bus.result, bus.ctrl},
          {25'd0, 4'b0000, v.res, v.ctrl});

      // back-to-back single-cycle accepts
      bus.in_valid = 1'b1; bus.alu_op = 3'b010; bus.funct = 6'h26; bus.src_a = 32'h3; bus.src_b = 32'h5;
      @(negedge clk);
      chk("b2b_first", {27'd0, bus.out_valid, bus.result, bus.ctrl}, {27'd0, 1'b1, 32'h6, 4'b0011});
      bus.alu_op = 3'b001; bus.src_a = 32'hA; bus.src_b = 32'h3;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("b2b_second", {27'd0, bus.out_valid, bus.result, bus.ctrl}, {27'd0, 1'b1, 32'h7, 4'b0110});

`ifdef ALU_MULDIV_EN
      drive(3'b010, 6'h18, 32'hFFFFFFFD, 32'h5);
      wait_done("mult_neg", 34, 4'b1101);
      hilo("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFF1);
      drive(3'b010, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done("multu_max", 34, 4'b1101);
      hilo("multu_max", 32'hFFFFFFFE, 32'h00000001);
      drive(3'b010, 6'h18, 32'h7FFFFFFF, 32'h80000000);
      wait_done("mult_ext", 34, 4'b1101);
      hilo("mult_ext", 32'hC0000000, 32'h80000000);
      drive(3'b010, 6'h1A, 32'hFFFFFFF9, 32'h2);
      wait_done("div_neg", 34, 4'b1110);
      hilo("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
      drive(3'b010, 6'h1A, 32'h7, 32'hFFFFFFFE);
      wait_done("div_negb", 34, 4'b1110);
      hilo("div_negb", 32'h00000001, 32'hFFFFFFFD);
      drive(3'b010, 6'h1A, 32'h80000000, 32'hFFFFFFFF);
      wait_done("div_minneg", 34, 4'b1110);
      hilo("div_minneg", 32'h0, 32'h80000000);
      drive(3'b010, 6'h1A, 32'hFFFFFFF9, 32'h0);
      wait_done("div_zero", 34, 4'b1110);
      hilo("div_zero", 32'hFFFFFFF9, 32'hFFFFFFFF);

      // mflo held behind a running mult is taken the cycle after SIGN
      bus.in_valid = 1'b1; bus.alu_op = 3'b010; bus.funct = 6'h19; bus.src_a = 32'h6; bus.src_b = 32'h7;
      @(negedge clk);
      bus.funct = 6'h12;
      n = 1;
      while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
      chk("hold_lat", 64'(n), 64'd34);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("hold_mflo", {27'd0, bus.out_valid, bus.result, bus.ctrl}, {27'd0, 1'b1, 32'd42, 4'b1010});

      drive(3'b010, 6'h1B, 32'h9, 32'h0);
      wait_done("divu_zero", 34, 4'b1110);
      hilo("divu_zero", 32'h9, 32'hFFFFFFFF);

      // reset mid-multiply aborts with no completion and clears HI/LO
      drive(3'b010, 6'h19, 32'hFFFFFFFF, 32'h2);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_state", {61'd0, bus.busy, bus.in_ready, bus.out_valid}, 64'b010);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.out_valid) pulses++;
      end
      chk("abort_nopulse", 64'(pulses), 64'd0);
      hilo("abort", 32'h0, 32'h0);
`else
      begin
         logic [5:0] md_fn[6];
         md_fn = '{6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B};
         foreach (md_fn[i]) begin
            drive(3'b010, md_fn[i], 32'hFFFFFFFD, 32'h5);
            chk($sformatf("nomd_%h", md_fn[i]),
                {24'd0, bus.out_valid, bus.err, bus.wb_en, bus.ctrl, bus.result, bus.busy, bus.in_ready},
                {24'd0, 3'b110, 4'b1111, 32'h0, 2'b01});
         end
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_ctrl_exec.md
Name: alu_ctrl_exec

Overview:
- Parametrised successor to the single-cycle ALU control decoder: decodes ALUOp/funct, executes the operation and registers the result.
- Adds a multi-cycle multiply/divide engine with HI/LO registers, a valid/ready handshake and an overflow flag.
- Sits in the EX stage between the main control unit and the register-file writeback path.

Parameters:
- WIDTH, 32, datapath width in bits; legal values are 4 or greater.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request; high only in IDLE.
- alu_op  input  3  main-control op class.
- funct  input  6  R-type function field.
- src_a  input  WIDTH  operand A / dividend / multiplicand.
- src_b  input  WIDTH  operand B / divisor / multiplier.
- out_valid  output  1  one-cycle completion pulse.
- result  output  WIDTH  registered result.
- wb_en  output  1  result must be written back; qualified by out_valid.
- ctrl  output  4  registered decoded ALU control code.
- ovf  output  1  signed overflow on add/sub; qualified by out_valid.
- err  output  1  illegal alu_op/funct; qualified by out_valid.
- busy  output  1  multi-cycle operation in progress; pipeline stall.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, HI=LO=0, all outputs 0 except in_ready=1. Reset mid-operation aborts it with no out_valid pulse.
- Accept: the edge where in_valid & in_ready are both high.
- alu_op decode:
  - 000 and 011 -> add, ctrl 0010.
  - 001 -> sub, ctrl 0110.
  - 100 -> and, ctrl 0000.
  - 101 -> or, ctrl 0001.
  - 110 -> slt, ctrl 0111.
  - 010 -> decode funct.
  - 111 -> illegal.
- R-type funct decode:
  - 20 add, ctrl 0010, signed, ovf checked.
  - 21 addu, ctrl 0010.
  - 22 sub, ctrl 0110, ovf checked.
  - 23 subu, ctrl 0110.
  - 24 and, ctrl 0000.
  - 25 or, ctrl 0001.
  - 26 xor, ctrl 0011.
  - 27 nor, ctrl 1100.
  - 2A slt, ctrl 0111.
  - 2B sltu, ctrl 1000.
  - 10 mfhi, ctrl 1001.
  - 12 mflo, ctrl 1010.
  - 18 mult, ctrl 1101.
  - 19 multu, ctrl 1101.
  - 1A div, ctrl 1110.
  - 1B divu, ctrl 1110.
  - Any other funct -> illegal.
- Illegal op: ctrl=1111, err=1, wb_en=0, result=0. Latency is 1.
- Single-cycle ops (including mfhi/mflo): out_valid is high in the cycle after accept (latency 1).
  - result uses WIDTH-bit wraparound arithmetic.
  - slt/sltu return a zero-extended 0/1.
  - wb_en=1.
- Overflow: add/sub signed overflow sets ovf=1 and wb_en=0; result still shows the wrapped sum.
- FSM states: IDLE, MUL, DIV, SIGN.
  - IDLE -> MUL or DIV on accepting a mult*/div*. Operands are latched as magnitudes for the signed variants; result signs are recorded.
  - MUL: shift-add, one bit per cycle, for WIDTH cycles; the counter counts 0..WIDTH-1.
  - DIV: restoring divide, one quotient bit per cycle, for WIDTH cycles.
  - SIGN: one cycle; applies negation, writes HI/LO, pulses out_valid with wb_en=0, returns to IDLE.
- Multi-cycle latency: out_valid is high exactly WIDTH+2 cycles after the accept cycle. busy=1 and in_ready=0 from the cycle after accept through the SIGN cycle.
- mult/multu: {HI,LO} = 2*WIDTH-bit product.
- div/divu: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- Divide by zero: HI = src_a, LO = all ones. No err; latency unchanged.
- Signed most-negative / -1: LO = most-negative value, HI = 0.
- mfhi/mflo while busy: impossible because in_ready=0. The caller must hold in_valid.
- A back-to-back accept is allowed in the cycle where out_valid is asserted for single-cycle ops. For multi-cycle ops it is allowed from the cycle after SIGN.
- All registered outputs other than result/ctrl hold 0 when out_valid=0. result and ctrl hold their last value.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: mult/div engine, HI/LO registers and mfhi/mflo are present as specified above.
- Undefined:
  - funct 10/12/18/19/1A/1B decode as illegal (ctrl 1111, err=1, latency 1).
  - No HI/LO registers.
  - The FSM reduces to IDLE only; busy is tied 0 and in_ready is tied 1.

Test Plan:
- alu_op=010, funct=20, a=5, b=7 -> one cycle later: out_valid=1, result=12, ctrl=0010, wb_en=1, ovf=0.
- funct=20, a=7FFFFFFF, b=1 -> result=80000000, ovf=1, wb_en=0. Same operands with funct=21 -> ovf=0, wb_en=1.
- funct=18, a=FFFFFFFD (-3), b=5 -> out_valid exactly 34 cycles after accept. A following mfhi returns FFFFFFFF; mflo returns FFFFFFF1.
- funct=1A, a=FFFFFFF9 (-7), b=2 -> LO=FFFFFFFD, HI=FFFFFFFF. funct=1B, a=9, b=0 -> HI=9, LO=FFFFFFFF, latency 34.
- Start multu, assert rst_n=0 at cycle 10 -> busy=0 and in_ready=1 immediately, no out_valid pulse, mfhi after release returns 0.
- alu_op=010, funct=3F -> ctrl=1111, err=1, wb_en=0. Build with ALU_MULDIV_EN undefined, funct=18 -> err=1, latency 1.
